// File: rtl/fsm_transition_sequencer_if.sv
// Handshake bundle between the transition sequencer and its environment.
// The master drives requester/resource/FSM-feedback inputs; the slave drives the strobes.
interface fsm_transition_sequencer_if;
    logic i_req;
    logic i_rsrcReady;
    logic i_release;
    logic i_grantActive;
    logic o_stateTransition1;
    logic o_stateTransition2;
    logic o_stateTransition3;
    logic o_stateTransition4;
    logic o_busy;
    logic o_timeout;
    logic o_desync;

    modport master (
        output i_req,
        output i_rsrcReady,
        output i_release,
        output i_grantActive,
        input  o_stateTransition1,
        input  o_stateTransition2,
        input  o_stateTransition3,
        input  o_stateTransition4,
        input  o_busy,
        input  o_timeout,
        input  o_desync
    );

    modport slave (
        input  i_req,
        input  i_rsrcReady,
        input  i_release,
        input  i_grantActive,
        output o_stateTransition1,
        output o_stateTransition2,
        output o_stateTransition3,
        output o_stateTransition4,
        output o_busy,
        output o_timeout,
        output o_desync
    );
endinterface

// File: rtl/fsm_transition_sequencer.sv
// Drives the request/grant FSM with single-cycle transition strobes from a shadow state,
// bounding grant hold time, enforcing a minimum revoke time and checking FSM grant feedback.
module fsm_transition_sequencer #(
    parameter int HOLD_MAX      = 16,
    parameter int REVOKE_CYCLES = 4
) (
    input logic                           i_ck,
    input logic                           i_arst,
    fsm_transition_sequencer_if.slave     bus
);
    localparam int HW = $clog2(HOLD_MAX);
    localparam int RW = $clog2(REVOKE_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;
    localparam logic [1:0] S_REV   = 2'd3;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [RW-1:0] REV_LAST  = RW'(REVOKE_CYCLES - 1);

    logic [1:0]    r_state;
    logic [HW-1:0] r_hold;
    logic [RW-1:0] r_rev;
    logic          r_t1, r_t2, r_t3, r_t4;
    logic          r_timeout;
    logic          r_grantExp;
    logic          r_desync;

    logic [1:0]    w_next;
    logic          w_t1, w_t2, w_t3, w_t4;
    logic          w_timeout;

    always_comb begin
        w_next    = r_state;
        w_t1      = 1'b0;
        w_t2      = 1'b0;
        w_t3      = 1'b0;
        w_t4      = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_req) begin
                    w_next = S_REQ;
                    w_t1   = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.i_rsrcReady) begin
                    w_next = S_GRANT;
                    w_t2   = 1'b1;
                end
            end
            S_GRANT: begin
                // A release on the limit cycle is a normal release, not a timeout.
                if (bus.i_release) begin
                    w_next = S_REV;
                    w_t3   = 1'b1;
                end else if (r_hold == HOLD_LAST) begin
                    w_next    = S_REV;
                    w_t3      = 1'b1;
                    w_timeout = 1'b1;
                end
            end
            S_REV: begin
                if (r_rev == REV_LAST && !bus.i_req) begin
                    w_next = S_IDLE;
                    w_t4   = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_ck or posedge i_arst) begin
        if (i_arst) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_rev      <= '0;
            r_t1       <= 1'b0;
            r_t2       <= 1'b0;
            r_t3       <= 1'b0;
            r_t4       <= 1'b0;
            r_timeout  <= 1'b0;
            r_grantExp <= 1'b0;
            r_desync   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_t1      <= w_t1;
            r_t2      <= w_t2;
            r_t3      <= w_t3;
            r_t4      <= w_t4;
            r_timeout <= w_timeout;

            if (w_t2) begin
                r_hold <= '0;
            end else if (r_state == S_GRANT && !w_t3) begin
                r_hold <= r_hold + HW'(1);
            end

            if (w_t3) begin
                r_rev <= '0;
            end else if (r_state == S_REV && r_rev != REV_LAST) begin
                r_rev <= r_rev + RW'(1);
            end

            // The FSM lags the shadow by one edge, so compare against a delayed copy.
            r_grantExp <= (r_state == S_GRANT);
            if (bus.i_grantActive != r_grantExp) begin
                r_desync <= 1'b1;
            end
        end
    end

    assign bus.o_stateTransition1 = r_t1;
    assign bus.o_stateTransition2 = r_t2;
    assign bus.o_stateTransition3 = r_t3;
    assign bus.o_stateTransition4 = r_t4;
    assign bus.o_busy             = (r_state != S_IDLE);
    assign bus.o_timeout          = r_timeout;
    assign bus.o_desync           = r_desync;
endmodule

// File: tb/tb_fsm_transition_sequencer.sv
// Directed bench for fsm_transition_sequencer with a behavioural model of the downstream FSM.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_fsm_transition_sequencer;
    logic clk = 1'b0;
    logic arst;
    logic force_g;
    logic [1:0] fsm;
    int ncmp = 0;
    int nerr = 0;
    logic seen;

    always #5 clk = ~clk;

    fsm_transition_sequencer_if sif ();

    fsm_transition_sequencer #(
        .HOLD_MAX      (16),
        .REVOKE_CYCLES (4)
    ) dut (
        .i_ck   (clk),
        .i_arst (arst),
        .bus    (sif)
    );

    // Downstream FSM: advances one edge after each strobe.
    always @(posedge clk or posedge arst) begin
        if (arst) fsm <= 2'd0;
        else if (sif.o_stateTransition1) fsm <= 2'd1;
        else if (sif.o_stateTransition2) fsm <= 2'd2;
        else if (sif.o_stateTransition3) fsm <= 2'd3;
        else if (sif.o_stateTransition4) fsm <= 2'd0;
    end

    assign sif.i_grantActive = (fsm == 2'd2) | force_g;

    wire [3:0] t = {sif.o_stateTransition4, sif.o_stateTransition3,
                    sif.o_stateTransition2, sif.o_stateTransition1};
    wire [6:0] outs = {t, sif.o_busy, sif.o_timeout, sif.o_desync};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_idle();
        sif.i_req = 1'b0;
        sif.i_release = 1'b0;
        sif.i_rsrcReady = 1'b0;
        for (int i = 0; i < 12 && sif.o_busy; i++) step();
        chk("to_idle", sif.o_busy, 1'b0);
    endtask

    initial begin
        arst = 1'b1;
        force_g = 1'b0;
        sif.i_req = 1'b0;
        sif.i_rsrcReady = 1'b0;
        sif.i_release = 1'b0;
        #12;
        chk("reset_outs", outs, 7'd0);
        step();
        arst = 1'b0;
        step();
        chk("post_reset_outs", outs, 7'd0);

        // Normal pass: t1, t2, t3, t4 in order
        sif.i_req = 1'b1;
        step();
        chk("n_t1", t, 4'b0001);
        chk("n_busy", sif.o_busy, 1'b1);
        step();
        chk("n_req_c1", t, 4'b0000);
        step();
        chk("n_req_c2", t, 4'b0000);
        sif.i_rsrcReady = 1'b1;
        step();
        chk("n_t2", t, 4'b0010);
        sif.i_rsrcReady = 1'b0;
        repeat (4) step();
        chk("n_grant_quiet", t, 4'b0000);
        chk("n_fsm_grant", sif.i_grantActive, 1'b1);
        sif.i_release = 1'b1;
        sif.i_req = 1'b0;
        step();
        chk("n_t3", t, 4'b0100);
        chk("n_no_timeout", sif.o_timeout, 1'b0);
        sif.i_release = 1'b0;
        repeat (3) step();
        chk("n_revoke_min", t, 4'b0000);
        step();
        chk("n_t4", t, 4'b1000);
        chk("n_idle_busy", sif.o_busy, 1'b0);
        step();
        chk("n_quiet", t, 4'b0000);
        chk("n_desync", sif.o_desync, 1'b0);

        // Hold limit: forced revoke after 16 GRANT cycles
        sif.i_req = 1'b1;
        step();
        sif.i_rsrcReady = 1'b1;
        step();
        chk("h_t2", t, 4'b0010);
        sif.i_req = 1'b0;
        sif.i_rsrcReady = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            step();
            if (sif.o_stateTransition3 || sif.o_timeout) seen = 1'b1;
        end
        chk("h_early", seen, 1'b0);
        step();
        chk("h_t3", t, 4'b0100);
        chk("h_timeout", sif.o_timeout, 1'b1);
        step();
        chk("h_timeout_pulse", sif.o_timeout, 1'b0);
        to_idle();
        chk("h_desync", sif.o_desync, 1'b0);

        // Release on the limit cycle wins over timeout
        sif.i_req = 1'b1;
        step();
        sif.i_rsrcReady = 1'b1;
        step();
        sif.i_req = 1'b0;
        sif.i_rsrcReady = 1'b0;
        repeat (15) step();
        chk("l_no_t3_yet", t, 4'b0000);
        sif.i_release = 1'b1;
        step();
        chk("l_t3", t, 4'b0100);
        chk("l_no_timeout", sif.o_timeout, 1'b0);
        sif.i_release = 1'b0;
        to_idle();

        // Request held through REVOKE withholds t4
        sif.i_req = 1'b1;
        step();
        sif.i_rsrcReady = 1'b1;
        step();
        sif.i_rsrcReady = 1'b0;
        sif.i_release = 1'b1;
        step();
        chk("r_t3", t, 4'b0100);
        sif.i_release = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            step();
            if (sif.o_stateTransition4) seen = 1'b1;
        end
        chk("r_t4_withheld", seen, 1'b0);
        chk("r_busy", sif.o_busy, 1'b1);
        sif.i_req = 1'b0;
        step();
        chk("r_t4", t, 4'b1000);
        chk("r_busy_fall", sif.o_busy, 1'b0);
        chk("r_desync", sif.o_desync, 1'b0);

        // Async reset in the middle of GRANT
        sif.i_req = 1'b1;
        step();
        sif.i_rsrcReady = 1'b1;
        step();
        sif.i_req = 1'b0;
        sif.i_rsrcReady = 1'b0;
        repeat (3) step();
        chk("a_grant", sif.i_grantActive, 1'b1);
        #2 arst = 1'b1;
        #1;
        chk("a_outs", outs, 7'd0);
        #2 arst = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            step();
            if (t != 4'b0000) seen = 1'b1;
        end
        chk("a_no_strobes", seen, 1'b0);
        chk("a_idle", sif.o_busy, 1'b0);

        // Desync is sticky until reset
        force_g = 1'b1;
        step();
        chk("d_set", sif.o_desync, 1'b1);
        force_g = 1'b0;
        repeat (3) step();
        chk("d_held", sif.o_desync, 1'b1);
        sif.i_req = 1'b1;
        step();
        chk("d_t1_works", t, 4'b0001);
        sif.i_req = 1'b0;
        #2 arst = 1'b1;
        #1;
        chk("d_cleared", sif.o_desync, 1'b0);
        #2 arst = 1'b0;
        step();
        chk("d_stays_clear", sif.o_desync, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
